request_pending_controller_8: RTL and testbench
===============================================

# request_pending_controller_8

Sequential front-end that feeds the 8-3 high priority encoder and services its result. Rising edges on eight request lines are latched into pending bits. The unmasked pending bits drive the encoder's eight data inputs. The returned encoded index is captured and presented as a single interrupt with a valid/acknowledge handshake, and an acknowledge clears the serviced bit.

## Interface
Parameters:
- ACK_TIMEOUT, 16, number of consecutive un-acked SERVICE cycles before a presentation is withdrawn; 0 disables the timeout.

Ports:
- Clock_In  input  1  sole clock; all state updates on its rising edge
- Reset_In  input  1  synchronous, active-high reset
- Request_In  input  8  raw request lines; bit k is channel k
- Mask_In  input  8  1 = channel k blocked from presentation; its pending bit is kept
- Encoded_Value_In  input  3  index returned by the encoder for the current Data_k_Out pattern
- Data_0_Out..Data_7_Out  output  1 each  pending[k] & ~Mask_In[k], to the encoder's Data_k_In
- Irq_Valid_Out  output  1  interrupt presented
- Irq_Index_Out  output  3  channel being presented; stable while Irq_Valid_Out=1
- Ack_In  input  1  consumer acknowledge; meaningful only while Irq_Valid_Out=1
- Pending_Out  output  8  raw pending register
- Overflow_Out  output  8  sticky; an edge arrived on channel k while pending[k] was already 1
- Timeout_Out  output  1  one-cycle pulse when a presentation is withdrawn

## Operation
- Edge detect: prev register holds last sampled Request_In. Request_In[k]=1 & prev[k]=0 sets pending[k].
- Overflow: if an edge arrives and pending[k] is already 1, Overflow_Out[k] is set. It clears only on reset.
- any_req = OR of Data_k_Out. The block does not rely on the encoder output when any_req=0.
- FSM has two states: IDLE and SERVICE.
  - IDLE with any_req=1: capture Encoded_Value_In into Irq_Index_Out, set Irq_Valid_Out, clear the timeout counter, go to SERVICE.
  - IDLE with any_req=0: stay in IDLE with Irq_Valid_Out=0.
  - SERVICE with Ack_In=1: clear pending[Irq_Index_Out], drop Irq_Valid_Out, go to IDLE.
  - SERVICE with Ack_In=0: increment the counter. When ACK_TIMEOUT cycles have elapsed (ACK_TIMEOUT≠0), drop Irq_Valid_Out, pulse Timeout_Out, keep the pending bit, go to IDLE.
- Changes to Mask_In or new requests during SERVICE never alter Irq_Index_Out or revoke the current presentation.
- Simultaneous edge on channel k and ack of channel k: set wins. pending[k] stays 1, Overflow_Out[k] is not set, and the channel is re-presented.
- Ack_In while in IDLE is ignored.
- Timeout counter width is $clog2(ACK_TIMEOUT+1).
- Reset values: pending=0, Overflow_Out=0, Irq_Valid_Out=0, Irq_Index_Out=0, Timeout_Out=0, FSM=IDLE, counter=0, prev=8'hFF.
  - Because prev resets high, a line held high through reset creates no request; it must fall and rise again.
- Reset asserted mid-SERVICE abandons the presentation with no Timeout_Out pulse.

## Timing
- Edge sampled at clock edge e → pending[k] and Data_k_Out high after e → Irq_Valid_Out high after e+1. Latency is 2 edges.
- Ack sampled at edge a → Irq_Valid_Out low and pending bit clear after a.
  - IDLE occupies at least one cycle, so Irq_Valid_Out is low for ≥1 cycle between presentations.
  - The encoder sees the cleared pattern before the next capture.
- Timeout: the presentation is withdrawn at the edge ending the ACK_TIMEOUT-th consecutive un-acked SERVICE cycle. Ack_In=1 in that same cycle takes priority and no timeout occurs.
- Data_k_Out is combinational from the pending register and Mask_In; all other outputs are registered.

## Configuration
- Macro: REQUEST_LEVEL_MODE_EN.
- Defined: pending[k] is set every cycle Request_In[k]=1, level-sensitive. prev is unused, Overflow_Out is tied to 0, and a line held high after ack is re-latched on the same edge as the ack.
- Undefined (default): rising-edge detection with overflow tracking, as described above.

## Test plan
- Reset, then pulse Request_In=8'h28 for one cycle → Irq_Valid_Out high 2 edges later with Irq_Index_Out=5; ack → Irq_Index_Out=3 after one idle cycle; ack → Pending_Out=0, Irq_Valid_Out stays 0.
- Mask_In=8'h80 with a request on 7 and 2 → index 2 presented and acked; clear mask → index 7 presented.
- Request on 4, then a second edge on 4 before ack → Overflow_Out=8'h10; ack → Pending_Out[4]=0.
- ACK_TIMEOUT=4, request 6, no ack → Irq_Valid_Out drops after 4 SERVICE cycles; Timeout_Out pulses once; Pending_Out[6]=1; channel 6 re-presented.
- Edge on 1 in the same cycle as ack of 1 → Pending_Out[1] stays 1, no overflow, index 1 re-presented.
- Request_In=8'h01 held high across a Reset_In pulse during SERVICE → all outputs at reset values, no new pending until the line toggles.

Source files
------------

// File: rtl/request_pending_controller_8.sv
// Request latch and interrupt presenter wrapped around an external 8-3 priority encoder.
// Optional build macro REQUEST_LEVEL_MODE_EN selects level-sensitive request capture.
module request_pending_controller_8 #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       Clock_In,
    input  logic       Reset_In,
    input  logic [7:0] Request_In,
    input  logic [7:0] Mask_In,
    input  logic [2:0] Encoded_Value_In,
    input  logic       Ack_In,
    output logic       Data_0_Out,
    output logic       Data_1_Out,
    output logic       Data_2_Out,
    output logic       Data_3_Out,
    output logic       Data_4_Out,
    output logic       Data_5_Out,
    output logic       Data_6_Out,
    output logic       Data_7_Out,
    output logic       Irq_Valid_Out,
    output logic [2:0] Irq_Index_Out,
    output logic [7:0] Pending_Out,
    output logic [7:0] Overflow_Out,
    output logic       Timeout_Out
);

    // state   | meaning
    // IDLE    | nothing presented; capture encoder result when any unmasked bit pends
    // SERVICE | Irq_Index_Out presented, waiting for ack or timeout
    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int TERM  = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;

    state_t             state;
    state_t             state_next;
    logic [7:0]         pending;
    logic [7:0]         pending_next;
    logic [7:0]         data;
    logic               any_req;
    logic [7:0]         set_vec;
    logic [7:0]         clr_vec;
    logic               valid;
    logic               valid_next;
    logic [2:0]         index;
    logic [2:0]         index_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               timeout;
    logic               timeout_next;

    assign data    = pending & ~Mask_In;
    assign any_req = |data;

    assign Data_0_Out = data[0];
    assign Data_1_Out = data[1];
    assign Data_2_Out = data[2];
    assign Data_3_Out = data[3];
    assign Data_4_Out = data[4];
    assign Data_5_Out = data[5];
    assign Data_6_Out = data[6];
    assign Data_7_Out = data[7];

    assign Irq_Valid_Out = valid;
    assign Irq_Index_Out = index;
    assign Pending_Out   = pending;
    assign Timeout_Out   = timeout;

`ifdef REQUEST_LEVEL_MODE_EN
    assign set_vec      = Request_In;
    assign Overflow_Out = 8'h00;
`else
    logic [7:0] prev;
    logic [7:0] overflow;
    logic [7:0] ovf_set;

    assign set_vec      = Request_In & ~prev;
    // An edge coinciding with the ack of the same channel simply re-arms it.
    assign ovf_set      = set_vec & pending & ~clr_vec;
    assign Overflow_Out = overflow;

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            prev     <= 8'hFF;
            overflow <= 8'h00;
        end else begin
            prev     <= Request_In;
            overflow <= overflow | ovf_set;
        end
    end
`endif

    // Set takes priority over the ack clear of the same bit.
    assign pending_next = (pending & ~clr_vec) | set_vec;

    always_comb begin
        state_next   = state;
        valid_next   = valid;
        index_next   = index;
        cnt_next     = cnt;
        clr_vec      = 8'h00;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                valid_next = 1'b0;
                if (any_req) begin
                    index_next = Encoded_Value_In;
                    valid_next = 1'b1;
                    cnt_next   = '0;
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (Ack_In) begin
                    clr_vec    = 8'h01 << index;
                    valid_next = 1'b0;
                    state_next = IDLE;
                end else if ((ACK_TIMEOUT != 0) && (cnt == CNT_W'(TERM))) begin
                    valid_next   = 1'b0;
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state   <= IDLE;
            pending <= 8'h00;
            valid   <= 1'b0;
            index   <= 3'd0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            valid   <= valid_next;
            index   <= index_next;
            cnt     <= cnt_next;
            timeout <= timeout_next;
        end
    end

endmodule

// File: tb/tb_request_pending_controller_8.sv
// Directed bench for request_pending_controller_8 with an encoder model and index scoreboard.
module tb_request_pending_controller_8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic [2:0] enc;
    logic       ack;
    logic [7:0] data;
    logic       irq_valid;
    logic [2:0] irq_index;
    logic [7:0] pending;
    logic [7:0] overflow;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    int sb_q[$];

    always #5 clk = ~clk;

    request_pending_controller_8 #(.ACK_TIMEOUT(4)) dut (
        .Clock_In         (clk),
        .Reset_In         (rst),
        .Request_In       (req),
        .Mask_In          (mask),
        .Encoded_Value_In (enc),
        .Ack_In           (ack),
        .Data_0_Out       (data[0]),
        .Data_1_Out       (data[1]),
        .Data_2_Out       (data[2]),
        .Data_3_Out       (data[3]),
        .Data_4_Out       (data[4]),
        .Data_5_Out       (data[5]),
        .Data_6_Out       (data[6]),
        .Data_7_Out       (data[7]),
        .Irq_Valid_Out    (irq_valid),
        .Irq_Index_Out    (irq_index),
        .Pending_Out      (pending),
        .Overflow_Out     (overflow),
        .Timeout_Out      (timeout)
    );

    // Highest set index wins.
    always_comb begin
        enc = 3'd0;
        for (int i = 0; i < 8; i++)
            if (data[i]) enc = 3'(i);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        int exp_idx;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed presentation expected none queued", tag);
        end else begin
            exp_idx = sb_q.pop_front();
            check(tag, {29'd0, irq_index}, exp_idx);
        end
    endtask

    task automatic expect_present(input string tag);
        int n = 0;
        while (!irq_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'd0, irq_valid}, 1);
        if (irq_valid) pop_check({tag, "_index"});
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        mask = 8'h00;
        ack  = 1'b0;
        tick();
        tick();
        check("rst_pending",  pending,   8'h00);
        check("rst_valid",    irq_valid, 0);
        check("rst_index",    irq_index, 0);
        check("rst_overflow", overflow,  8'h00);
        check("rst_timeout",  timeout,   0);
        rst = 1'b0;
        tick();

        // two requests, presented highest first, exact latency
        req = 8'h28;
        sb_q.push_back(5);
        sb_q.push_back(3);
        tick();
        req = 8'h00;
        check("t1_pending", pending, 8'h28);
        check("t1_lat_valid", irq_valid, 0);
        tick();
        check("t1_valid5", irq_valid, 1);
        pop_check("t1_index5");
        do_ack();
        check("t1_gap_valid", irq_valid, 0);
        check("t1_pending_after_ack", pending, 8'h08);
        tick();
        check("t1_valid3", irq_valid, 1);
        pop_check("t1_index3");
        do_ack();
        check("t1_pending_clear", pending, 8'h00);
        tick();
        tick();
        check("t1_idle_valid", irq_valid, 0);

        // masking
        mask = 8'h80;
        req  = 8'h84;
        tick();
        req = 8'h00;
        sb_q.push_back(2);
        expect_present("t2_ch2");
        do_ack();
        tick();
        check("t2_masked_pending", pending, 8'h80);
        check("t2_masked_valid", irq_valid, 0);
        mask = 8'h00;
        sb_q.push_back(7);
        expect_present("t2_ch7");
        do_ack();
        check("t2_pending_clear", pending, 8'h00);

        // overflow
        req = 8'h10;
        tick();
        req = 8'h00;
        sb_q.push_back(4);
        expect_present("t3_ch4");
        req = 8'h10;
        tick();
        req = 8'h00;
        check("t3_overflow", overflow, 8'h10);
        check("t3_still_valid", irq_valid, 1);
        check("t3_still_index", irq_index, 4);
        do_ack();
        check("t3_pending_clear", pending, 8'h00);
        check("t3_overflow_sticky", overflow, 8'h10);

        // timeout after 4 un-acked service cycles
        req = 8'h40;
        tick();
        req = 8'h00;
        sb_q.push_back(6);
        expect_present("t4_ch6");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_hold_valid", irq_valid, 1);
            check("t4_hold_timeout", timeout, 0);
        end
        tick();
        check("t4_withdrawn", irq_valid, 0);
        check("t4_timeout_pulse", timeout, 1);
        check("t4_pending_kept", pending, 8'h40);
        tick();
        check("t4_timeout_once", timeout, 0);
        check("t4_represent_valid", irq_valid, 1);
        sb_q.push_back(6);
        pop_check("t4_represent_index");
        do_ack();
        check("t4_pending_clear", pending, 8'h00);

        // edge and ack of the same channel together
        req = 8'h02;
        tick();
        req = 8'h00;
        sb_q.push_back(1);
        expect_present("t5_ch1");
        req = 8'h02;
        ack = 1'b1;
        tick();
        req = 8'h00;
        ack = 1'b0;
        check("t5_pending_kept", pending, 8'h02);
        check("t5_no_overflow", overflow, 8'h10);
        check("t5_gap_valid", irq_valid, 0);
        tick();
        check("t5_represent_valid", irq_valid, 1);
        sb_q.push_back(1);
        pop_check("t5_represent_index");
        do_ack();

        // reset mid-service with the line held high
        req = 8'h01;
        tick();
        sb_q.push_back(0);
        expect_present("t6_ch0");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_pending",  pending,   8'h00);
        check("t6_rst_valid",    irq_valid, 0);
        check("t6_rst_index",    irq_index, 0);
        check("t6_rst_overflow", overflow,  8'h00);
        check("t6_rst_timeout",  timeout,   0);
        tick();
        tick();
        tick();
        check("t6_held_pending", pending, 8'h00);
        check("t6_held_valid", irq_valid, 0);
        check("t6_held_timeout", timeout, 0);
        req = 8'h00;
        tick();
        req = 8'h01;
        tick();
        check("t6_retoggle_pending", pending, 8'h01);
        sb_q.push_back(0);
        expect_present("t6_retoggle");
        req = 8'h00;
        do_ack();
        check("t6_final_pending", pending, 8'h00);

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
